fir_param_pipe: RTL
===================

Name: fir_param_pipe

Overview:
Parametrised, pipelined direct-form FIR filter with a valid-qualified sample stream and run-time coefficient loading. It has a rounding and saturating output stage and a sticky overflow flag. It is the next-generation FIR for the Filters library: generic tap count and widths replace the fixed 6-tap/16-bit datapath. It sits between the sample source (ADC front end or test generator) and downstream DSP stages.

Parameters:
DATA_W, 12, signed input sample width
COEF_W, 16, signed coefficient width
TAPS, 8, number of taps (2..64)
OUT_W, 16, signed output width
SHIFT, 15, arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1)
ACC_W (localparam), DATA_W+COEF_W+clog2(TAPS), full-precision accumulator width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_data is a new sample this cycle
in_data  in  DATA_W  signed input sample
flush  in  1  synchronous clear of the delay line and valid pipeline
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  tap index to write
coef_data  in  COEF_W  signed coefficient value
sat_clr  in  1  synchronous clear of sat_flag
out_valid  out  1  out_data holds a new result
out_data  out  OUT_W  signed filtered output
sat_flag  out  1  sticky: at least one output saturated since last clear

Behaviour:
- Reset (rst=1, async): delay line, coefficients, products, accumulator, valid pipeline, out_data, out_valid and sat_flag all go to 0.
- Delay line: advances only at an edge where in_valid=1. At that edge, d[0]<=in_data and d[k]<=d[k-1]. With in_valid=0 the delay line holds; gaps never insert zeros.
- Pipeline, for a sample accepted at edge E:
  - E+1: p[k] <= coef[k]*d[k], full COEF_W+DATA_W signed.
  - E+2: acc <= sum of all p[k], sign-extended to ACC_W.
  - E+3: out_data <= sat(round(acc)), out_valid=1.
- Latency is exactly 3 edges after acceptance. One result per accepted sample, in order. Back-to-back input gives one output per cycle.
- out_valid is a 3-stage shadow of in_valid. out_valid is 1 for one cycle per accepted sample. out_data holds its last value while out_valid=0.
- Rounding:
  - If SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT, round half toward +inf.
  - If SHIFT=0: r = acc.
  - The add is performed in ACC_W+1 bits so it cannot wrap.
- Saturation:
  - r > 2^(OUT_W-1)-1 → out_data = 2^(OUT_W-1)-1.
  - r < -2^(OUT_W-1) → out_data = -2^(OUT_W-1).
  - Either clamp sets sat_flag on the same edge out_valid rises.
  - Clamping is only evaluated on valid outputs.
- sat_flag: sticky. A sat_clr edge clears it. If a saturating output and sat_clr occur at the same edge, the set wins and sat_flag=1.
- Coefficient write:
  - At an edge with coef_we=1 and coef_addr<TAPS: coef[coef_addr]<=coef_data.
  - coef_addr>=TAPS (non-power-of-2 TAPS) is ignored.
  - A new value is used by every product stage evaluated after the write edge. A write issued at the same edge as a sample's product stage does not affect that sample.
  - Writes are legal at any time; the filter does not stall.
- flush=1 at an edge:
  - Delay line and all valid-pipeline bits clear to 0. In-flight results are discarded, so no out_valid follows.
  - flush takes precedence over a simultaneous in_valid: that sample is dropped.
  - Coefficients, out_data and sat_flag are unaffected.
- Reset mid-stream: in-flight samples are lost. out_valid=0 from the reset assertion until 3 edges after the first post-reset accepted sample.

Test Plan:
- Impulse response (TAPS=8, SHIFT=0, OUT_W=16): load coef[k]=k+1. Feed 1 then 7 zeros on consecutive cycles → outputs 1,2,3,4,5,6,7,8; first out_valid 3 edges after the impulse edge.
- Bubbles: same setup; feed the impulse then zeros with in_valid deasserted every other cycle → same sequence 1..8. out_valid pattern mirrors in_valid delayed by 3 edges.
- Rounding (SHIFT=1): coef[0]=1, others 0. Input 3 → out 2; input -3 → out -1; input 2 → out 1. sat_flag stays 0.
- Saturation (SHIFT=0, OUT_W=16): all coef=0x7FFF, continuous input 0x7FF → out_data=32767, sat_flag=1. Input 0x800 → out_data=-32768. sat_clr with no further saturation → sat_flag=0. sat_clr on a saturating edge → sat_flag stays 1.
- Coefficient update and flush:
  - Mid-stream, write coef[0]=0 at the edge after a sample's product stage; that sample is unchanged and later ones reflect the new value.
  - Assert flush together with in_valid while 2 results are in flight → no out_valid for 3 cycles; the dropped sample never appears.
- Async reset: assert rst between edges during streaming → out_valid and out_data go to 0 immediately, without a clock. After release, coefficients read 0, so the outputs are 0 until coefficients are reloaded.

Source files
------------

// File: rtl/fir_param_pipe_if.sv
// Sample stream, coefficient load and result bus of the parametrised FIR.
// The master side drives samples/controls; the slave side is the filter.
interface fir_param_pipe_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned OUT_W  = 16
);
    localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     flush;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     sat_clr;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     sat_flag;

    modport master (
        output in_valid, in_data, flush, coef_we, coef_addr, coef_data, sat_clr,
        input  out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, in_data, flush, coef_we, coef_addr, coef_data, sat_clr,
        output out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/fir_param_pipe.sv
// Pipelined direct-form FIR: delay line -> products -> accumulator -> round/saturate.
// Three edges of latency per accepted sample, run-time coefficient writes, sticky saturation flag.
module fir_param_pipe #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SHIFT  = 15
) (
    input  logic           clk,
    input  logic           rst,
    fir_param_pipe_if.slave bus
);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
    localparam int unsigned RW     = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;

    localparam logic signed [RW-1:0] MAX_R    = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] MIN_R    = RW'(-(64'sd1 <<< (OUT_W - 1)));
    localparam logic signed [RW-1:0] RND_HALF =
        (SHIFT == 0) ? '0 : RW'(64'sd1 <<< ((SHIFT == 0) ? 0 : SHIFT - 1));

    logic signed [DATA_W-1:0] d_q    [TAPS];
    logic signed [DATA_W-1:0] d_d    [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [2:0]               vld_q, vld_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     sat_flag_q, sat_flag_d;

    logic signed [RW-1:0]     acc_ext;
    logic signed [RW-1:0]     rnd_sum;
    logic signed [RW-1:0]     rnd_res;
    logic                     clamp_hi;
    logic                     clamp_lo;
    logic                     emit;

    // Delay line shifts only on accepted samples; flush wins over in_valid.
    always_comb begin
        d_d = d_q;
        if (bus.flush) begin
            for (int unsigned k = 0; k < TAPS; k++) d_d[k] = '0;
        end else if (bus.in_valid) begin
            d_d[0] = bus.in_data;
            for (int unsigned k = 1; k < TAPS; k++) d_d[k] = d_q[k-1];
        end
    end

    // Coefficient bank; out-of-range addresses are dropped.
    always_comb begin
        coef_d = coef_q;
        if (bus.coef_we && (32'(bus.coef_addr) < TAPS)) begin
            coef_d[bus.coef_addr] = bus.coef_data;
        end
    end

    // Products use the coefficient value held before this edge's write.
    always_comb begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(d_q[k]);
        end
    end

    always_comb begin
        acc_d = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc_d = acc_d + ACC_W'(prod_q[k]);
        end
    end

    // Valid shadow: bit0 = sample in delay line, bit1 = products, bit2 = accumulator.
    always_comb begin
        vld_d = bus.flush ? 3'b000 : {vld_q[1:0], bus.in_valid};
    end

    // Round half toward +inf in a widened domain, then clamp to OUT_W.
    always_comb begin
        acc_ext  = RW'(acc_q);
        rnd_sum  = acc_ext + RND_HALF;
        rnd_res  = rnd_sum >>> SHIFT;
        clamp_hi = (rnd_res > MAX_R);
        clamp_lo = (rnd_res < MIN_R);
        emit     = vld_q[2] && !bus.flush;
    end

    always_comb begin
        out_valid_d = emit;
        out_data_d  = out_data_q;
        sat_flag_d  = sat_flag_q && !bus.sat_clr;
        if (emit) begin
            if (clamp_hi) begin
                out_data_d = OUT_W'(MAX_R);
            end else if (clamp_lo) begin
                out_data_d = OUT_W'(MIN_R);
            end else begin
                out_data_d = OUT_W'(rnd_res);
            end
            if (clamp_hi || clamp_lo) sat_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q         <= '{default: '0};
            coef_q      <= '{default: '0};
            prod_q      <= '{default: '0};
            acc_q       <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            d_q         <= d_d;
            coef_q      <= coef_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_flag_q;
endmodule
